shade_out_arbiter: RTL and testbench
====================================

Name: shade_out_arbiter

Overview:
- Collects shaded-pixel results from NUM_CORES ray cores and merges them into one registered stream for the framebuffer writer.
- Each core has a 2-entry skid FIFO; a round-robin arbiter drains them, with a valid/ready handshake toward the writer.
- Also counts the pixels emitted per frame and flags frame completion to the renderer state machine. This replaces summing per-core pixel counters.

Parameters:
- NUM_CORES, 4, number of ray-core inputs (1..8)
- DATA_W, 64, width of one packed ShadeOutputData word
- PIXEL_COUNT, 76800, pixels per frame (320x240)
- CNT_W, 17, pixel counter width; must satisfy 2^CNT_W > PIXEL_COUNT

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- core_valid  in  NUM_CORES  per-core shade result valid
- core_data  in  NUM_CORES*DATA_W  per-core shade result; core i occupies bits [i*DATA_W +: DATA_W]
- core_full  out  NUM_CORES  per-core FIFO full; the core must not assert valid while this is high
- out_valid  out  1  merged result valid
- out_data  out  DATA_W  merged result
- out_src  out  $clog2(NUM_CORES) (min 1)  index of the originating core
- out_ready  in  1  framebuffer writer accepts
- frame_start  in  1  one-cycle pulse; clears the frame counter
- frame_done  out  1  sticky; high once PIXEL_COUNT pixels have been emitted
- pixel_count  out  CNT_W  pixels emitted this frame
- overflow  out  1  sticky; set when a push arrives while that core's FIFO is full
- perf_stall_cycles  out  16  see Optional Feature

Behaviour:
- Reset (async, resetn=0):
  - All FIFOs empty and core_full=0.
  - out_valid=0, out_data=0, out_src=0.
  - Round-robin pointer=0.
  - pixel_count=0, frame_done=0, overflow=0, perf_stall_cycles=0.
  - Reset mid-operation discards all buffered data.
- Per-core FIFO:
  - Depth 2.
  - core_full is registered: high exactly when occupancy==2.
  - Push and pop in the same cycle is allowed; occupancy is unchanged and order is preserved.
  - Push while full: data dropped, overflow set, FIFO unchanged.
- Arbitration:
  - The output register loads when out_valid==0 or out_ready==1.
  - On a load cycle, grant the first non-empty FIFO searching from the pointer upward, with wrap-around.
  - Pop the granted FIFO and load out_data/out_src. The pointer becomes (grant+1) mod NUM_CORES.
  - No non-empty FIFO on a load cycle: out_valid<=0 and the pointer is unchanged.
  - While out_valid=1 and out_ready=0, out_data and out_src are held stable.
- Latency:
  - A push captured at the edge ending cycle t reaches out_valid=1 in cycle t+2 at the earliest.
  - Sustained throughput is 1 word/cycle with out_ready held high.
- Fairness: with every FIFO non-empty, grants cycle 0,1,..,NUM_CORES-1,0...
- Frame counter:
  - Each handshake (out_valid & out_ready) increments pixel_count.
  - A handshake that makes pixel_count==PIXEL_COUNT sets frame_done.
  - Further handshakes saturate pixel_count at PIXEL_COUNT.
  - frame_start clears pixel_count and frame_done. It does not flush the FIFOs or the output register.
  - frame_start in the same cycle as a handshake: frame_start wins and pixel_count=0.
- core_full is purely a function of this block's FIFO state. It does not depend on out_ready in the same cycle.

Optional Feature:
- Macro: SHADE_ARB_PERF_EN.
- Defined:
  - perf_stall_cycles counts cycles with out_valid=1 and out_ready=0, saturating at 16'hFFFF.
  - Cleared by frame_start.
- Undefined: perf_stall_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Shared package: ShadeOutputData typedef, and FRAMEBUFFER_PIXEL_COUNT / RAY_CORE_SIZE constants. These feed the PIXEL_COUNT and NUM_CORES defaults.
- One natural sub-module, shade_skid_fifo: 2-entry FIFO with push, pop, full, empty. It is instantiated per core in a generate loop.
- Arbiter, output register and counters stay in the top module.

Test Plan:
- Single word: NUM_CORES=4; core 2 pushes 64'hA5 with out_ready=1 → out_valid=1 two cycles later, out_data=64'hA5, out_src=2, pixel_count=1.
- Round robin: all 4 cores push simultaneously with out_ready=1 → out_src sequence 0,1,2,3 on consecutive cycles; pointer ends at 0.
- Backpressure: out_ready=0 for 10 cycles while core 0 pushes every cycle → core_full[0]=1 after the 3rd accepted word (2 in FIFO + 1 in output register); out_data held stable; on release, words drain in order.
- Overflow: core 1 pushes while core_full[1]=1 → overflow=1, word absent from the output, remaining order intact.
- Frame done: PIXEL_COUNT=8; 8 handshakes → frame_done=1 and pixel_count=8; a 9th handshake leaves pixel_count=8; frame_start coincident with a handshake → pixel_count=0 and frame_done=0.
- Perf: with SHADE_ARB_PERF_EN defined, 5 stalled cycles → perf_stall_cycles=5; without the macro → perf_stall_cycles=0. Assert resetn=0 mid-stream → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/shade_out_arbiter_pkg.sv
// Shared types and constants for the shade output merge path.
package shade_out_arbiter_pkg;
  localparam int SHADE_DATA_W            = 64;
  localparam int FRAMEBUFFER_PIXEL_COUNT = 320 * 240;
  localparam int RAY_CORE_SIZE           = 4;

  typedef logic [SHADE_DATA_W-1:0] ShadeOutputData;
endpackage

// File: rtl/shade_skid_fifo.sv
// Two-entry skid FIFO in front of the shade output arbiter; one per ray core.
module shade_skid_fifo #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic              drop
);
  logic [DATA_W-1:0] mem_reg [2];
  logic [1:0]        count_reg, count_next;
  logic              wr_ptr_reg, rd_ptr_reg, full_reg;
  logic              do_push, do_pop;

  // A push into a full FIFO is discarded even if a pop happens the same cycle.
  assign do_push  = push & ~full_reg;
  assign do_pop   = pop & (count_reg != 2'd0);
  assign drop     = push & full_reg;
  assign full     = full_reg;
  assign empty    = (count_reg == 2'd0);
  assign pop_data = mem_reg[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop)
      count_next = count_reg + 2'd1;
    else if (do_pop && !do_push)
      count_next = count_reg - 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_reg[0] <= '0;
      mem_reg[1] <= '0;
      count_reg  <= 2'd0;
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      full_reg   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_reg[wr_ptr_reg] <= push_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_pop)
        rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_next;
      full_reg  <= (count_next == 2'd2);
    end
  end
endmodule

// File: rtl/shade_out_arbiter.sv
// Merges per-core shade results into one registered stream with round-robin
// arbitration and a per-frame pixel counter. Optional stall counter: SHADE_ARB_PERF_EN.
module shade_out_arbiter
  import shade_out_arbiter_pkg::*;
#(
  parameter int NUM_CORES   = RAY_CORE_SIZE,
  parameter int DATA_W      = $bits(ShadeOutputData),
  parameter int PIXEL_COUNT = FRAMEBUFFER_PIXEL_COUNT,
  parameter int CNT_W       = 17,
  localparam int SRC_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_CORES-1:0]        core_valid,
  input  logic [NUM_CORES*DATA_W-1:0] core_data,
  output logic [NUM_CORES-1:0]        core_full,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [SRC_W-1:0]            out_src,
  input  logic                        out_ready,
  input  logic                        frame_start,
  output logic                        frame_done,
  output logic [CNT_W-1:0]            pixel_count,
  output logic                        overflow,
  output logic [15:0]                 perf_stall_cycles
);
  localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(PIXEL_COUNT);

  logic [DATA_W-1:0]    fifo_data [NUM_CORES];
  logic [NUM_CORES-1:0] fifo_empty, fifo_pop, fifo_drop;

  logic                 out_valid_reg, frame_done_reg, overflow_reg;
  logic [DATA_W-1:0]    out_data_reg;
  logic [SRC_W-1:0]     out_src_reg, rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]     pixel_count_reg;

  logic                 load, handshake, grant_valid;
  logic [SRC_W-1:0]     grant_idx;
  logic [DATA_W-1:0]    grant_data;

  generate
    for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      shade_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (core_valid[gi]),
        .push_data (core_data[gi*DATA_W +: DATA_W]),
        .pop       (fifo_pop[gi]),
        .pop_data  (fifo_data[gi]),
        .full      (core_full[gi]),
        .empty     (fifo_empty[gi]),
        .drop      (fifo_drop[gi])
      );
      assign fifo_pop[gi] = load & grant_valid & (grant_idx == SRC_W'(gi));
    end
  endgenerate

  assign load      = ~out_valid_reg | out_ready;
  assign handshake = out_valid_reg & out_ready;

  // First non-empty FIFO at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_ptr_reg) + k) % NUM_CORES;
      if (!grant_valid && !fifo_empty[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = SRC_W'(idx);
        grant_data  = fifo_data[idx];
      end
    end
    rr_ptr_next = (int'(grant_idx) == NUM_CORES - 1) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      rr_ptr_reg    <= '0;
    end else if (load) begin
      out_valid_reg <= grant_valid;
      if (grant_valid) begin
        out_data_reg <= grant_data;
        out_src_reg  <= grant_idx;
        rr_ptr_reg   <= rr_ptr_next;
      end
    end
  end

  // frame_start takes priority over a coincident handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pixel_count_reg <= '0;
      frame_done_reg  <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      if (frame_start) begin
        pixel_count_reg <= '0;
        frame_done_reg  <= 1'b0;
      end else if (handshake && pixel_count_reg != PIX_MAX) begin
        pixel_count_reg <= pixel_count_reg + 1'b1;
        if (pixel_count_reg + 1'b1 == PIX_MAX)
          frame_done_reg <= 1'b1;
      end
      if (|fifo_drop)
        overflow_reg <= 1'b1;
    end
  end

`ifdef SHADE_ARB_PERF_EN
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      stall_cnt_reg <= 16'd0;
    else if (frame_start)
      stall_cnt_reg <= 16'd0;
    else if (out_valid_reg && !out_ready && stall_cnt_reg != 16'hFFFF)
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
  end

  assign perf_stall_cycles = stall_cnt_reg;
`else
  assign perf_stall_cycles = 16'd0;
`endif

  assign out_valid   = out_valid_reg;
  assign out_data    = out_data_reg;
  assign out_src     = out_src_reg;
  assign frame_done  = frame_done_reg;
  assign pixel_count = pixel_count_reg;
  assign overflow    = overflow_reg;
endmodule

// File: tb/tb_shade_out_arbiter.sv
// Directed bench for shade_out_arbiter (4 cores, 8-pixel frame).
module tb_shade_out_arbiter;
  localparam int NC = 4;
  localparam int DW = 64;
  localparam int PC = 8;
  localparam int CW = 4;

  logic              clk = 1'b0;
  logic              resetn;
  logic [NC-1:0]     core_valid;
  logic [NC*DW-1:0]  core_data;
  logic [NC-1:0]     core_full;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;
  logic              out_ready;
  logic              frame_start;
  logic              frame_done;
  logic [CW-1:0]     pixel_count;
  logic              overflow;
  logic [15:0]       perf_stall_cycles;

  int passed = 0;
  int total  = 0;
  int accepted;
  logic [15:0] perf_exp;

  shade_out_arbiter #(
    .NUM_CORES(NC), .DATA_W(DW), .PIXEL_COUNT(PC), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .core_valid(core_valid), .core_data(core_data),
    .core_full(core_full), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_ready(out_ready), .frame_start(frame_start),
    .frame_done(frame_done), .pixel_count(pixel_count), .overflow(overflow),
    .perf_stall_cycles(perf_stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int core, input logic [63:0] d);
    core_valid[core]            = 1'b1;
    core_data[core*DW +: DW]    = d;
  endtask

  task automatic do_reset();
    core_valid  = '0;
    core_data   = '0;
    out_ready   = 1'b0;
    frame_start = 1'b0;
    resetn      = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  initial begin
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_core_full", core_full, 0);
    chk("rst_pixel_count", pixel_count, 0);
    chk("rst_flags", {frame_done, overflow}, 0);
    chk("rst_perf", perf_stall_cycles, 0);

    // Single word from core 2
    do_reset();
    out_ready = 1'b1;
    push(2, 64'hA5);
    step();
    core_valid = '0;
    chk("single_not_yet", out_valid, 0);
    step();
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 64'hA5);
    chk("single_src", out_src, 2);
    step();
    chk("single_count", pixel_count, 1);
    chk("single_drained", out_valid, 0);

    // Round robin, all cores at once
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < NC; i++) push(i, 64'h100 + 64'(i));
    step();
    core_valid = '0;
    for (int i = 0; i < NC; i++) begin
      step();
      chk("rr_src", out_src, i);
      chk("rr_data", out_data, 64'h100 + 64'(i));
    end
    push(3, 64'h33);
    push(0, 64'h30);
    step();
    core_valid = '0;
    step();
    chk("rr_wrap_src", out_src, 0);
    chk("rr_count", pixel_count, 4);

    // Backpressure on core 0
    do_reset();
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      core_valid = '0;
      if (!core_full[0]) begin
        push(0, 64'h200 + 64'(accepted));
        accepted++;
      end
      step();
      if (i == 1) chk("bp_full_early", core_full[0], 0);
      if (i == 2) chk("bp_full_third", core_full[0], 1);
    end
    core_valid = '0;
    chk("bp_accepted", accepted, 3);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_data", out_data, 64'h200);
    out_ready = 1'b1;
    step();
    chk("bp_drain1", out_data, 64'h201);
    chk("bp_full_release", core_full[0], 0);
    step();
    chk("bp_drain2", out_data, 64'h202);
    step();
    chk("bp_empty", out_valid, 0);

    // Overflow on core 1
    do_reset();
    push(1, 64'h11); step();
    push(1, 64'h12); step();
    push(1, 64'h13); step();
    chk("ov_full", core_full[1], 1);
    chk("ov_not_yet", overflow, 0);
    push(1, 64'hEE); step();
    core_valid = '0;
    chk("ov_set", overflow, 1);
    chk("ov_hold", out_data, 64'h11);
    out_ready = 1'b1;
    step();
    chk("ov_order1", out_data, 64'h12);
    step();
    chk("ov_order2", out_data, 64'h13);
    step();
    chk("ov_dropped", out_valid, 0);
    chk("ov_sticky", overflow, 1);

    // Frame counter
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < PC; i++) begin
      push(0, 64'h300 + 64'(i));
      step();
    end
    core_valid = '0;
    chk("fr_count6", pixel_count, 6);
    chk("fr_done_early", frame_done, 0);
    step();
    step();
    chk("fr_count8", pixel_count, 8);
    chk("fr_done", frame_done, 1);
    push(0, 64'h3FF); step();
    core_valid = '0;
    step();
    step();
    chk("fr_saturate", pixel_count, 8);
    push(0, 64'h3FE); step();
    core_valid = '0;
    step();
    chk("fr_fs_pending", out_valid, 1);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("fr_fs_count", pixel_count, 0);
    chk("fr_fs_done", frame_done, 0);

    // Stall counter and asynchronous reset
    do_reset();
    push(0, 64'h400); step();
    core_valid = '0;
    step();
    for (int i = 0; i < 5; i++) step();
`ifdef SHADE_ARB_PERF_EN
    perf_exp = 16'd5;
`else
    perf_exp = 16'd0;
`endif
    chk("perf_stall", perf_stall_cycles, perf_exp);
    push(1, 64'h401); push(2, 64'h402); step();
    core_valid = '0;
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_full", core_full, 0);
    chk("arst_perf", perf_stall_cycles, 0);
    step();
    resetn    = 1'b1;
    out_ready = 1'b1;
    step();
    step();
    chk("arst_flushed", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
